rule_stream_arbiter: RTL and testbench
======================================

# rule_stream_arbiter

Packet-granular round-robin arbiter that shares one 128-bit rule-stream consumer, such as the 128-to-64 rule depacker, among NUM_IN independent rule sources. A grant is held from the first accepted beat of a packet until its eop beat is accepted, so rule packets are never interleaved. A registered output stage carries the winning source ID alongside every beat, and a per-source packet counter is kept for status.

## Interface
Parameters:
- NUM_IN, 4, number of requesting rule sources (2..8)
- DATA_W, 128, beat width in bits
- EMPTY_W, 4, width of the empty field
- SRC_W, 2, width of the source ID; must be at least clog2(NUM_IN)

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  NUM_IN  per-source beat valid
- in_sop  in  NUM_IN  per-source start of packet
- in_eop  in  NUM_IN  per-source end of packet
- in_empty  in  NUM_IN*EMPTY_W  flattened; source i occupies [i*EMPTY_W +: EMPTY_W]
- in_data  in  NUM_IN*DATA_W  flattened; source i occupies [i*DATA_W +: DATA_W]
- in_ready  out  NUM_IN  per-source ready
- out_valid  out  1  output beat valid
- out_sop  out  1  output start of packet
- out_eop  out  1  output end of packet
- out_empty  out  EMPTY_W  output empty field
- out_data  out  DATA_W  output beat data
- out_src  out  SRC_W  index of the source that produced the beat
- out_ready  in  1  consumer ready
- busy  out  1  high while a grant is held
- pkt_cnt  out  NUM_IN*32  per-source count of completed packets; wraps at 2^32

## Operation
Handshake:
- A beat transfers when valid and ready are both high in the same cycle, on both the input and output sides.
- Output stage is one register. Its accept condition is stage_ready = !out_valid | out_ready.

States:
- IDLE
  - No grant is held; in_ready is all zero.
  - If any in_valid bit is high, choose the first valid source searching from (last_grant+1) mod NUM_IN upward, wrapping.
  - Register the winner as grant and as last_grant, then go to LOCKED.
  - If no in_valid bit is high, stay in IDLE.
- LOCKED
  - in_ready[grant] = stage_ready; all other in_ready bits are 0.
  - On each input transfer, load the output register with the beat fields, set out_src = grant, and set out_valid = 1.
  - When the transferred beat has eop=1: increment pkt_cnt[grant] and return to IDLE.
- Output register:
  - Cleared (out_valid = 0) when out_ready is high and no new beat loads in the same cycle.
  - When it empties and loads in the same cycle, the new beat wins.

Rules:
- Arbitration is combinational on in_valid during IDLE only. in_valid dropping mid-packet does not release the grant; the arbiter waits indefinitely.
- sop is not checked. Beats are forwarded as received, and only eop ends the grant.
- A single-beat packet (sop=1, eop=1) is granted, forwarded, and released like any other packet.
- Data, sop, empty and src hold their values while out_valid=1 and out_ready=0.
- busy = (state == LOCKED).

## Timing
- Reset (rst_n low, asynchronous):
  - state = IDLE, last_grant = NUM_IN-1, so source 0 has first priority.
  - in_ready = 0; out_valid, out_sop and out_eop = 0; out_data, out_empty and out_src = 0.
  - busy = 0; every pkt_cnt = 0.
- Reset asserted mid-packet: the partial packet is dropped immediately with no eop emitted. The consumer is responsible for discarding it.
- Grant latency: a request seen in IDLE cycle t gets in_ready at t+1, at the earliest.
- Datapath latency: an input transfer at cycle t appears on out_* at t+1.
- Throughput: 1 beat per cycle while LOCKED with out_ready held high. There is exactly one idle cycle between packets, the IDLE cycle after an eop.
- Backpressure: when out_ready=0 with out_valid=1, in_ready[grant] drops in the same cycle, combinationally through stage_ready.
- pkt_cnt updates on the cycle after the eop input transfer and wraps from 0xFFFFFFFF to 0.

## Test plan
- Reset, then source 0 alone sends 3 beats (sop on beat 0, eop on beat 2, data 0x1,0x2,0x3), out_ready=1.
  - out beats 0x1,0x2,0x3 on cycles 2..4 after in_valid rises; out_src=0; pkt_cnt[0]=1; busy returns to 0.
- All 4 sources hold 1-beat packets continuously.
  - Grant order is 0,1,2,3,0; one output beat every 2 cycles; each pkt_cnt advances equally.
- Source 1 is mid-packet (beat 1 of 4) while source 0 asserts valid.
  - Source 1 completes all 4 beats before source 0 gets in_ready; no interleaving on out_*.
- out_ready held low for 5 cycles mid-packet.
  - out_* stable throughout; in_ready[grant]=0 while out_valid=1; no beat lost or duplicated after release.
- in_valid of the granted source gaps for 3 cycles mid-packet while source 2 is valid.
  - Grant holds; source 2 stays unserved until the eop of the granted source transfers.
- rst_n pulsed low during beat 2 of a packet.
  - All outputs return to reset values immediately; after release, source 0 wins the first arbitration.

Source files
------------

// File: rtl/rule_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding one rule-stream consumer.
// The grant is held from the first accepted beat of a packet until its eop
// beat is accepted. The output register carries the source ID with each beat.
module rule_stream_arbiter #(
  parameter int unsigned NUM_IN  = 4,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned EMPTY_W = 4,
  parameter int unsigned SRC_W   = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_IN-1:0]           in_valid,
  input  logic [NUM_IN-1:0]           in_sop,
  input  logic [NUM_IN-1:0]           in_eop,
  input  logic [NUM_IN*EMPTY_W-1:0]   in_empty,
  input  logic [NUM_IN*DATA_W-1:0]    in_data,
  output logic [NUM_IN-1:0]           in_ready,
  output logic                        out_valid,
  output logic                        out_sop,
  output logic                        out_eop,
  output logic [EMPTY_W-1:0]          out_empty,
  output logic [DATA_W-1:0]           out_data,
  output logic [SRC_W-1:0]            out_src,
  input  logic                        out_ready,
  output logic                        busy,
  output logic [NUM_IN*32-1:0]        pkt_cnt
);

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_t;

  state_t               state_q, state_d;
  logic [SRC_W-1:0]     grant_q, grant_d;
  logic [SRC_W-1:0]     last_grant_q, last_grant_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_sop_q, out_sop_d;
  logic                 out_eop_q, out_eop_d;
  logic [EMPTY_W-1:0]   out_empty_q, out_empty_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic [SRC_W-1:0]     out_src_q, out_src_d;
  logic [31:0]          pkt_cnt_q [NUM_IN];
  logic [31:0]          pkt_cnt_d [NUM_IN];

  logic                 stage_ready;
  logic                 in_xfer;
  logic                 arb_found;
  logic [SRC_W-1:0]     arb_idx;
  logic [SRC_W-1:0]     cand_idx;

  assign stage_ready = !out_valid_q || out_ready;
  assign in_xfer     = (state_q == ST_LOCKED) && in_valid[grant_q] && stage_ready;

  // Round-robin pick: first valid source after last_grant, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = last_grant_q;
    cand_idx  = '0;
    for (int unsigned i = 1; i <= NUM_IN; i++) begin
      cand_idx = SRC_W'((32'(last_grant_q) + i) % NUM_IN);
      if (!arb_found && in_valid[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  // Only the granted source sees ready, gated by the output stage.
  always_comb begin
    in_ready = '0;
    if (state_q == ST_LOCKED) begin
      in_ready[grant_q] = stage_ready;
    end
  end

  // Next-state, output register and packet counter update.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_sop_d    = out_sop_q;
    out_eop_d    = out_eop_q;
    out_empty_d  = out_empty_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    pkt_cnt_d    = pkt_cnt_q;

    if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          grant_d      = arb_idx;
          last_grant_d = arb_idx;
          state_d      = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (in_xfer) begin
          // A load in the same cycle as a drain overrides the clear above.
          out_valid_d = 1'b1;
          out_sop_d   = in_sop[grant_q];
          out_eop_d   = in_eop[grant_q];
          out_empty_d = in_empty[32'(grant_q)*EMPTY_W +: EMPTY_W];
          out_data_d  = in_data[32'(grant_q)*DATA_W +: DATA_W];
          out_src_d   = grant_q;
          if (in_eop[grant_q]) begin
            pkt_cnt_d[grant_q] = pkt_cnt_q[grant_q] + 32'd1;
            state_d            = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= SRC_W'(NUM_IN - 1);
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_empty_q  <= '0;
      out_data_q   <= '0;
      out_src_q    <= '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        pkt_cnt_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      out_empty_q  <= out_empty_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      pkt_cnt_q    <= pkt_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_empty = out_empty_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign busy      = (state_q == ST_LOCKED);

  for (genvar g = 0; g < int'(NUM_IN); g++) begin : g_cnt
    assign pkt_cnt[g*32 +: 32] = pkt_cnt_q[g];
  end

endmodule

// File: tb/tb_rule_stream_arbiter.sv
// Scoreboard bench for rule_stream_arbiter: per-source beat queues drive the
// inputs, expected output beats are queued in arbitration order and popped
// as the DUT emits them.
module tb_rule_stream_arbiter;

  localparam int unsigned NI = 4;
  localparam int unsigned DW = 128;
  localparam int unsigned EW = 4;
  localparam int unsigned SW = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NI-1:0]       in_valid, in_sop, in_eop, in_ready;
  logic [NI*EW-1:0]    in_empty;
  logic [NI*DW-1:0]    in_data;
  logic                out_valid, out_sop, out_eop, out_ready;
  logic [EW-1:0]       out_empty;
  logic [DW-1:0]       out_data;
  logic [SW-1:0]       out_src;
  logic                busy;
  logic [NI*32-1:0]    pkt_cnt;

  always #5 clk = ~clk;

  rule_stream_arbiter #(
    .NUM_IN (NI),
    .DATA_W (DW),
    .EMPTY_W(EW),
    .SRC_W  (SW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_sop   (in_sop),
    .in_eop   (in_eop),
    .in_empty (in_empty),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_sop  (out_sop),
    .out_eop  (out_eop),
    .out_empty(out_empty),
    .out_data (out_data),
    .out_src  (out_src),
    .out_ready(out_ready),
    .busy     (busy),
    .pkt_cnt  (pkt_cnt)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_t;

  typedef struct {
    logic [SW-1:0] src;
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    int            cyc;
  } exp_t;

  beat_t          src_q [NI][$];
  exp_t           exp_q [$];
  logic [NI-1:0]  en, en_next, acc;
  logic           or_next;
  int             cyc;
  int             checks;
  int             failures;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void drive();
    for (int i = 0; i < int'(NI); i++) begin
      if (en[i] && src_q[i].size() > 0) begin
        in_valid[i]          = 1'b1;
        in_sop[i]            = src_q[i][0].sop;
        in_eop[i]            = src_q[i][0].eop;
        in_empty[i*EW +: EW] = src_q[i][0].empty;
        in_data[i*DW +: DW]  = src_q[i][0].data;
      end else begin
        in_valid[i]          = 1'b0;
        in_sop[i]            = 1'b0;
        in_eop[i]            = 1'b0;
        in_empty[i*EW +: EW] = '0;
        in_data[i*DW +: DW]  = '0;
      end
    end
  endfunction

  // Queue a packet on a source and its expected output beats on the scoreboard.
  task automatic push_pkt(input int src, input int nbeats, input logic [DW-1:0] base,
                          input int first_cyc, input int spacing);
    beat_t b;
    exp_t  e;
    for (int k = 0; k < nbeats; k++) begin
      b.data  = base + DW'(k);
      b.sop   = (k == 0);
      b.eop   = (k == nbeats - 1);
      b.empty = EW'(k + 1);
      src_q[src].push_back(b);
      e.src   = SW'(src);
      e.data  = b.data;
      e.sop   = b.sop;
      e.eop   = b.eop;
      e.empty = b.empty;
      e.cyc   = (first_cyc < 0) ? -1 : first_cyc + k * spacing;
      exp_q.push_back(e);
    end
  endtask

  // One clock: retire accepted beats, drive, then sample mid-cycle.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < int'(NI); i++) begin
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    en        = en_next;
    out_ready = or_next;
    drive();
    #1;
    acc = in_valid & in_ready;
    chk("ready_onehot", DW'($onehot0(in_ready)), DW'(1));
    if (out_valid && out_ready) begin
      chk("beat_expected", DW'(exp_q.size() > 0), DW'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_src",   DW'(out_src),   DW'(e.src));
        chk("out_data",  out_data,       e.data);
        chk("out_sop",   DW'(out_sop),   DW'(e.sop));
        chk("out_eop",   DW'(out_eop),   DW'(e.eop));
        chk("out_empty", DW'(out_empty), DW'(e.empty));
        if (e.cyc >= 0) chk("beat_cycle", DW'(cyc), DW'(e.cyc));
      end
    end
  endtask

  task automatic drain(input int budget);
    int  n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      step();
      n++;
      done = (exp_q.size() == 0);
      for (int i = 0; i < int'(NI); i++) if (src_q[i].size() > 0) done = 1'b0;
    end
    chk("drain_done", DW'(done), DW'(1));
  endtask

  task automatic clear_stim();
    for (int i = 0; i < int'(NI); i++) src_q[i].delete();
    exp_q.delete();
    acc       = '0;
    en        = '1;
    en_next   = '1;
    or_next   = 1'b1;
    out_ready = 1'b1;
    drive();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_out_valid"}, DW'(out_valid), '0);
    chk({tag, "_out_sop"},   DW'(out_sop),   '0);
    chk({tag, "_out_eop"},   DW'(out_eop),   '0);
    chk({tag, "_out_data"},  out_data,       '0);
    chk({tag, "_out_empty"}, DW'(out_empty), '0);
    chk({tag, "_out_src"},   DW'(out_src),   '0);
    chk({tag, "_busy"},      DW'(busy),      '0);
    chk({tag, "_in_ready"},  DW'(in_ready),  '0);
    chk({tag, "_pkt_cnt"},   DW'(pkt_cnt),   '0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    clear_stim();
    #1;
    check_reset_vals(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] cnt(input int i);
    return pkt_cnt[i*32 +: 32];
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "bench timed out");
  end

  initial begin
    int c0;
    int n;
    logic [DW-1:0] cap_data;
    logic [SW-1:0] cap_src;
    logic          cap_sop, cap_eop;

    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    clear_stim();

    // Lone 3-beat packet from source 0 with exact output timing.
    do_reset("rst0");
    c0 = cyc + 1;
    begin
      beat_t b;
      exp_t  e;
      for (int k = 0; k < 3; k++) begin
        b.data = DW'(k + 1); b.sop = (k == 0); b.eop = (k == 2); b.empty = EW'(k);
        src_q[0].push_back(b);
        e.src = '0; e.data = b.data; e.sop = b.sop; e.eop = b.eop; e.empty = b.empty;
        e.cyc = c0 + 2 + k;
        exp_q.push_back(e);
      end
    end
    drain(20);
    chk("t1_pkt_cnt0", DW'(cnt(0)), DW'(1));
    chk("t1_busy",     DW'(busy),   DW'(0));

    // All four sources with back-to-back single-beat packets.
    do_reset("rst1");
    c0 = cyc + 1;
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 4; s++)
        push_pkt(s, 1, DW'(32'hB000_0000 + 32'(s * 16 + p)), c0 + 2 + 2 * (p * 4 + s), 1);
    drain(40);
    for (int s = 0; s < 4; s++) chk("t2_pkt_cnt", DW'(cnt(s)), DW'(2));

    // Source 1 mid-packet must finish before source 0 is served.
    do_reset("rst2");
    push_pkt(1, 4, DW'(32'hC100_0000), -1, 1);
    n = 0;
    while (src_q[1].size() > 3 && n < 20) begin step(); n++; end
    push_pkt(0, 1, DW'(32'hC000_0000), -1, 1);
    n = 0;
    while (src_q[1].size() > 0 && n < 30) begin
      step(); n++;
      if (src_q[1].size() > 0) chk("t3_no_preempt", DW'(in_ready[0]), DW'(0));
    end
    drain(30);
    chk("t3_pkt_cnt1", DW'(cnt(1)), DW'(1));
    chk("t3_pkt_cnt0", DW'(cnt(0)), DW'(1));

    // Output backpressure for five cycles mid-packet.
    do_reset("rst3");
    push_pkt(2, 4, DW'(32'hD200_0000), -1, 1);
    n = 0;
    while (exp_q.size() > 2 && n < 20) begin step(); n++; end
    or_next = 1'b0;
    step();
    chk("t4_stall_valid", DW'(out_valid), DW'(1));
    cap_data = out_data; cap_src = out_src; cap_sop = out_sop; cap_eop = out_eop;
    chk("t4_stall_ready", DW'(in_ready), DW'(0));
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t4_hold_data",  out_data,       cap_data);
      chk("t4_hold_src",   DW'(out_src),   DW'(cap_src));
      chk("t4_hold_sop",   DW'(out_sop),   DW'(cap_sop));
      chk("t4_hold_eop",   DW'(out_eop),   DW'(cap_eop));
      chk("t4_hold_valid", DW'(out_valid), DW'(1));
      chk("t4_stall_ready", DW'(in_ready), DW'(0));
    end
    or_next = 1'b1;
    drain(30);
    chk("t4_pkt_cnt2", DW'(cnt(2)), DW'(1));

    // Granted source gaps for three cycles while source 2 waits.
    do_reset("rst4");
    push_pkt(0, 4, DW'(32'hE000_0000), -1, 1);
    push_pkt(2, 1, DW'(32'hE200_0000), -1, 1);
    n = 0;
    while (src_q[0].size() > 2 && n < 20) begin step(); n++; end
    en_next = 4'b1110;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_busy",        DW'(busy),        DW'(1));
      chk("t5_src2_blocked", DW'(in_ready[2]), DW'(0));
    end
    en_next = '1;
    drain(30);
    chk("t5_pkt_cnt0", DW'(cnt(0)), DW'(1));
    chk("t5_pkt_cnt2", DW'(cnt(2)), DW'(1));

    // Reset asserted during beat 2 of a packet from source 1.
    do_reset("rst5");
    push_pkt(1, 4, DW'(32'hF100_0000), -1, 1);
    n = 0;
    while (src_q[1].size() > 2 && n < 20) begin step(); n++; end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6_async");
    clear_stim();
    @(negedge clk);
    rst_n = 1'b1;
    push_pkt(0, 1, DW'(32'hF000_0000), -1, 1);
    push_pkt(3, 1, DW'(32'hF300_0000), -1, 1);
    drain(20);
    chk("t6_pkt_cnt0", DW'(cnt(0)), DW'(1));
    chk("t6_pkt_cnt1", DW'(cnt(1)), DW'(0));
    chk("t6_pkt_cnt3", DW'(cnt(3)), DW'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
